pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 15 +
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer_ras_stack.sv | 58 +++++
 rtl/pc_sequencer.sv | 135 +++++++++++++
 tb/tb_pc_sequencer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types for the PC sequencer: PC-source decode values and FSM states.
package pc_sequencer_pkg;

    localparam logic [1:0] PCSRC_BR  = 2'b00;
    localparam logic [1:0] PCSRC_JMP = 2'b01;
    localparam logic [1:0] PCSRC_SEQ = 2'b10;
    localparam logic [1:0] PCSRC_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder <-> sequencer bundle: decode/control inputs and fetch-side status.
interface pc_sequencer_if;

    logic        stall;
    logic        PCSrc1;
    logic        PCSrc0;
    logic        branch_taken;
    logic        is_call;
    logic        is_ret;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic        flush;
    logic        ras_full;
    logic        ras_empty;
    logic        fault;

    modport master (
        output stall, PCSrc1, PCSrc0, branch_taken, is_call, is_ret,
               branch_target, jump_target,
        input  pc, flush, ras_full, ras_empty, fault
    );

    modport slave (
        input  stall, PCSrc1, PCSrc0, branch_taken, is_call, is_ret,
               branch_target, jump_target,
        output pc, flush, ras_full, ras_empty, fault
    );

endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address stack with registered full/empty flags derived from the entry count.
module ras_stack #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        full,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] top_idx;

    always_comb begin
        count_d = count_q;
        if (push && !full_q)
            count_d = count_q + CW'(1);
        else if (pop && !empty_q)
            count_d = count_q - CW'(1);
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Contents need no reset: a zero count makes every entry unreachable.
    always_ff @(posedge clk) begin
        if (push && !full_q)
            mem[count_q[PW-1:0]] <= push_data;
    end

    // Low pointer bits minus one wraps correctly when count == DEPTH.
    assign top_idx = count_q[PW-1:0] - PW'(1);
    assign top     = mem[top_idx];
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection, redirect flush FSM and sticky fault handling around a return-address stack.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] FAULT_PC  = 32'h0000_000F,
    parameter int          RAS_DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        fault_q, fault_d;
    logic        ras_push, ras_pop;
    logic [31:0] ras_top;
    logic        ras_full, ras_empty;
    logic [1:0]  src;
    logic [31:0] pc_inc;
    logic        jmp_err;

    assign src     = {bus.PCSrc1, bus.PCSrc0};
    assign pc_inc  = pc_q + 32'd1;
    assign jmp_err = (bus.is_call && bus.is_ret) ||
                     (bus.is_call && ras_full)   ||
                     (bus.is_ret  && ras_empty);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flush_d  = flush_q;
        fault_d  = fault_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (!bus.stall) begin
                    flush_d = 1'b0;
                    case (src)
                        PCSRC_SEQ: pc_d = pc_inc;
                        PCSRC_BR: begin
                            if (bus.branch_taken) begin
                                pc_d    = bus.branch_target;
                                state_d = ST_FLUSH;
                                flush_d = 1'b1;
                            end else begin
                                pc_d = pc_inc;
                            end
                        end
                        PCSRC_JMP: begin
                            if (jmp_err) begin
                                pc_d    = FAULT_PC;
                                state_d = ST_FAULT;
                                fault_d = 1'b1;
                            end else begin
                                state_d = ST_FLUSH;
                                flush_d = 1'b1;
                                if (bus.is_call) begin
                                    ras_push = 1'b1;
                                    pc_d     = bus.jump_target;
                                end else if (bus.is_ret) begin
                                    ras_pop = 1'b1;
                                    pc_d    = ras_top;
                                end else begin
                                    pc_d = bus.jump_target;
                                end
                            end
                        end
                        default: begin
                            pc_d    = FAULT_PC;
                            state_d = ST_FAULT;
                            fault_d = 1'b1;
                        end
                    endcase
                end
            end
            // The instruction in decode is squashed, so its fields are ignored.
            ST_FLUSH: begin
                if (!bus.stall) begin
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                    flush_d = 1'b0;
                end
            end
            ST_FAULT: begin
                pc_d    = FAULT_PC;
                flush_d = 1'b0;
                fault_d = 1'b1;
            end
            default: begin
                pc_d    = FAULT_PC;
                state_d = ST_FAULT;
                flush_d = 1'b0;
                fault_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            fault_q <= fault_d;
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    assign bus.pc        = pc_q;
    assign bus.flush     = flush_q;
    assign bus.fault     = fault_q;
    assign bus.ras_full  = ras_full;
    assign bus.ras_empty = ras_empty;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: a vector table for the main flow plus hand-written multi-cycle corner cases.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    typedef struct {
        logic        stall;
        logic [1:0]  src;
        logic        tk;
        logic        call;
        logic        ret;
        logic [31:0] bt;
        logic [31:0] jt;
        logic [31:0] epc;
        logic        efl;
        logic        efull;
        logic        eempty;
        logic        eflt;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC  (32'h0000_0000),
        .FAULT_PC  (32'h0000_000F),
        .RAS_DEPTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] s, input logic tk, input logic c,
                         input logic r, input logic [31:0] bt, input logic [31:0] jt);
        bus.stall         = st;
        bus.PCSrc1        = s[1];
        bus.PCSrc0        = s[0];
        bus.branch_taken  = tk;
        bus.is_call       = c;
        bus.is_ret        = r;
        bus.branch_target = bt;
        bus.jump_target   = jt;
    endtask

    // Drive one decision, let one rising edge pass, sample 1ns later.
    task automatic step(input logic st, input logic [1:0] s, input logic tk, input logic c,
                        input logic r, input logic [31:0] bt, input logic [31:0] jt);
        drive(st, s, tk, c, r, bt, jt);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic [1:0] s, input logic tk, input logic c,
                       input logic r, input logic [31:0] bt, input logic [31:0] jt,
                       input logic [31:0] epc, input logic efl, input logic efull,
                       input logic eempty, input logic eflt);
        vec_t v;
        v.stall = st; v.src = s; v.tk = tk; v.call = c; v.ret = r; v.bt = bt; v.jt = jt;
        v.epc = epc; v.efl = efl; v.efull = efull; v.eempty = eempty; v.eflt = eflt;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        drive(1'b0, PCSRC_SEQ, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] epc, input logic efl,
                           input logic efull, input logic eempty, input logic eflt);
        chk({tag, ".pc"},        bus.pc,        epc);
        chk({tag, ".flush"},     {31'b0, bus.flush},     {31'b0, efl});
        chk({tag, ".ras_full"},  {31'b0, bus.ras_full},  {31'b0, efull});
        chk({tag, ".ras_empty"}, {31'b0, bus.ras_empty}, {31'b0, eempty});
        chk({tag, ".fault"},     {31'b0, bus.fault},     {31'b0, eflt});
    endtask

    initial begin
        // Main flow: sequential, branches, call/return, plain jump, stall, RAS overflow.
        add(0, PCSRC_SEQ, 0, 0, 0, 0, 0,             32'h1,  0, 0, 1, 0);
        add(0, PCSRC_SEQ, 0, 0, 0, 0, 0,             32'h2,  0, 0, 1, 0);
        add(0, PCSRC_SEQ, 0, 0, 0, 0, 0,             32'h3,  0, 0, 1, 0);
        add(0, PCSRC_BR,  0, 0, 0, 32'h99, 0,        32'h4,  0, 0, 1, 0);
        add(0, PCSRC_SEQ, 0, 0, 0, 0, 0,             32'h5,  0, 0, 1, 0);
        add(0, PCSRC_BR,  1, 0, 0, 32'h20, 0,        32'h20, 1, 0, 1, 0);
        add(0, PCSRC_ILL, 1, 1, 1, 32'h77, 32'h77,   32'h21, 0, 0, 1, 0);
        add(0, PCSRC_BR,  0, 0, 0, 32'h55, 0,        32'h22, 0, 0, 1, 0);
        add(0, PCSRC_BR,  1, 0, 0, 32'h3, 0,         32'h3,  1, 0, 1, 0);
        add(0, PCSRC_SEQ, 0, 0, 0, 0, 0,             32'h4,  0, 0, 1, 0);
        add(0, PCSRC_JMP, 0, 1, 0, 0, 32'h10,        32'h10, 1, 0, 0, 0);
        add(0, PCSRC_SEQ, 0, 0, 0, 0, 0,             32'h11, 0, 0, 0, 0);
        add(0, PCSRC_JMP, 0, 0, 1, 0, 32'h66,        32'h5,  1, 0, 1, 0);
        add(0, PCSRC_SEQ, 0, 0, 0, 0, 0,             32'h6,  0, 0, 1, 0);
        add(0, PCSRC_JMP, 0, 0, 0, 0, 32'h40,        32'h40, 1, 0, 1, 0);
        add(0, PCSRC_SEQ, 0, 0, 0, 0, 0,             32'h41, 0, 0, 1, 0);
        add(1, PCSRC_SEQ, 0, 0, 0, 0, 0,             32'h41, 0, 0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            add(0, PCSRC_JMP, 0, 1, 0, 0, 32'((k + 1) << 8),
                32'((k + 1) << 8), 1, (k == 7), 0, 0);
            add(0, PCSRC_SEQ, 0, 0, 0, 0, 0,
                32'(((k + 1) << 8) + 1), 0, (k == 7), 0, 0);
        end
        add(0, PCSRC_JMP, 0, 1, 0, 0, 32'h900,       32'hF,  0, 1, 0, 1);
        add(1, PCSRC_SEQ, 0, 0, 0, 0, 0,             32'hF,  0, 1, 0, 1);
        add(0, PCSRC_SEQ, 0, 0, 0, 0, 0,             32'hF,  0, 1, 0, 1);
        add(1, PCSRC_JMP, 0, 0, 1, 0, 0,             32'hF,  0, 1, 0, 1);
        add(0, PCSRC_JMP, 0, 0, 1, 0, 0,             32'hF,  0, 1, 0, 1);

        do_reset();
        chk_all("reset", 32'h0, 0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].stall, vecs[i].src, vecs[i].tk, vecs[i].call, vecs[i].ret,
                 vecs[i].bt, vecs[i].jt);
            chk_all($sformatf("vec%0d", i), vecs[i].epc, vecs[i].efl,
                    vecs[i].efull, vecs[i].eempty, vecs[i].eflt);
        end

        // Stall held three cycles inside FLUSH.
        do_reset();
        step(0, PCSRC_BR, 1, 0, 0, 32'h50, 0);
        chk_all("fstall.enter", 32'h50, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, PCSRC_SEQ, 0, 0, 0, 0, 0);
            chk_all($sformatf("fstall.hold%0d", i), 32'h50, 1, 0, 1, 0);
        end
        step(0, PCSRC_SEQ, 0, 0, 0, 0, 0);
        chk_all("fstall.done", 32'h51, 0, 0, 1, 0);

        // 32-bit wrap on a sequential advance.
        step(0, PCSRC_BR, 1, 0, 0, 32'hFFFF_FFFE, 0);
        step(0, PCSRC_SEQ, 0, 0, 0, 0, 0);
        chk_all("wrap.pre", 32'hFFFF_FFFF, 0, 0, 1, 0);
        step(0, PCSRC_SEQ, 0, 0, 0, 0, 0);
        chk_all("wrap.post", 32'h0, 0, 0, 1, 0);

        // Asynchronous reset mid-FLUSH with a live RAS entry.
        step(0, PCSRC_JMP, 0, 1, 0, 0, 32'h30);
        chk_all("arst.call", 32'h30, 1, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk_all("arst.async", 32'h0, 0, 0, 1, 0);
        #2 reset = 1'b0;
        step(0, PCSRC_SEQ, 0, 0, 0, 0, 0);
        chk_all("arst.run", 32'h1, 0, 0, 1, 0);
        step(0, PCSRC_JMP, 0, 0, 1, 0, 0);
        chk_all("arst.ret_empty", 32'hF, 0, 0, 1, 1);

        // call and ret together.
        do_reset();
        chk_all("rst2", 32'h0, 0, 0, 1, 0);
        step(0, PCSRC_SEQ, 0, 0, 0, 0, 0);
        step(0, PCSRC_JMP, 0, 1, 1, 0, 32'h44);
        chk_all("callret", 32'hF, 0, 0, 1, 1);

        // Illegal decode in RUN.
        do_reset();
        step(0, PCSRC_ILL, 0, 0, 0, 0, 0);
        chk_all("illegal", 32'hF, 0, 0, 1, 1);
        step(0, PCSRC_SEQ, 0, 0, 0, 0, 0);
        chk_all("illegal.sticky", 32'hF, 0, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
